// File: rtl/fp_mult_pipe.sv
// rtl/fp_mult_pipe.sv - pipelined parametrised floating-point multiplier with RNE rounding
module fp_mult_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [EXP_W+MAN_W:0] operand_a,
  input  logic [EXP_W+MAN_W:0] operand_b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+MAN_W:0] result,
  output logic [3:0]           flags
);

  localparam int W   = 1 + EXP_W + MAN_W;
  localparam int EW2 = EXP_W + 2;
  localparam int PW  = 2 * MAN_W + 2;

  localparam logic signed [EW2-1:0] BIAS    = EW2'((1 << (EXP_W - 1)) - 1);
  localparam logic signed [EW2-1:0] EXP_TOP = EW2'((1 << EXP_W) - 1);
  localparam logic signed [EW2-1:0] ONE_S   = EW2'(1);
  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  typedef enum logic [1:0] {CLS_NORM, CLS_NAN, CLS_INF, CLS_ZERO} cls_t;

  // One global enable: the whole pipe moves only when the output slot can drain.
  logic advance;
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  // Operand unpack and classification (subnormals are flushed to zero).
  logic             sign_a, sign_b;
  logic [EXP_W-1:0] exp_a, exp_b;
  logic [MAN_W-1:0] frac_a, frac_b;
  assign {sign_a, exp_a, frac_a} = operand_a;
  assign {sign_b, exp_b, frac_b} = operand_b;

  logic nan_a, nan_b, snan_a, snan_b, inf_a, inf_b, zero_a, zero_b;
  assign nan_a  = (&exp_a) && (|frac_a);
  assign nan_b  = (&exp_b) && (|frac_b);
  assign snan_a = nan_a && !frac_a[MAN_W-1];
  assign snan_b = nan_b && !frac_b[MAN_W-1];
  assign inf_a  = (&exp_a) && !(|frac_a);
  assign inf_b  = (&exp_b) && !(|frac_b);
  assign zero_a = !(|exp_a);
  assign zero_b = !(|exp_b);

  cls_t cls_d;
  logic inv_d;

  // Resolve the special-case class of the pair; earlier branches win.
  always_comb begin
    cls_d = CLS_NORM;
    inv_d = 1'b0;
    if (nan_a || nan_b) begin
      cls_d = CLS_NAN;
      inv_d = snan_a || snan_b;
    end else if ((inf_a && zero_b) || (zero_a && inf_b)) begin
      cls_d = CLS_NAN;
      inv_d = 1'b1;
    end else if (inf_a || inf_b) begin
      cls_d = CLS_INF;
    end else if (zero_a || zero_b) begin
      cls_d = CLS_ZERO;
    end
  end

  logic signed [EW2-1:0] exp_sum;
  assign exp_sum = $signed({2'b00, exp_a}) + $signed({2'b00, exp_b}) - BIAS;

  logic                  s1_valid, s1_sign, s1_inv;
  cls_t                  s1_cls;
  logic signed [EW2-1:0] s1_exp;
  logic [MAN_W:0]        s1_man_a, s1_man_b;

  // Stage 1: register unpacked operands, sign, exponent sum and class.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_sign  <= 1'b0;
      s1_inv   <= 1'b0;
      s1_cls   <= CLS_NORM;
      s1_exp   <= '0;
      s1_man_a <= '0;
      s1_man_b <= '0;
    end else if (advance) begin
      s1_valid <= in_valid;
      s1_sign  <= sign_a ^ sign_b;
      s1_inv   <= inv_d;
      s1_cls   <= cls_d;
      s1_exp   <= exp_sum;
      s1_man_a <= {1'b1, frac_a};
      s1_man_b <= {1'b1, frac_b};
    end
  end

  logic [PW-1:0]         prod, prod_norm;
  logic signed [EW2-1:0] exp_norm;
  assign prod = {{(MAN_W+1){1'b0}}, s1_man_a} * {{(MAN_W+1){1'b0}}, s1_man_b};

  // Normalise so the leading one lands in the top bit; no product bits are dropped.
  always_comb begin
    prod_norm = prod;
    exp_norm  = s1_exp + ONE_S;
    if (!prod[PW-1]) begin
      prod_norm = {prod[PW-2:0], 1'b0};
      exp_norm  = s1_exp;
    end
  end

  logic                  s2_valid, s2_sign, s2_inv;
  cls_t                  s2_cls;
  logic signed [EW2-1:0] s2_exp;
  logic [PW-1:0]         s2_man;

  // Stage 2: register the normalised product.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_sign  <= 1'b0;
      s2_inv   <= 1'b0;
      s2_cls   <= CLS_NORM;
      s2_exp   <= '0;
      s2_man   <= '0;
    end else if (advance) begin
      s2_valid <= s1_valid;
      s2_sign  <= s1_sign;
      s2_inv   <= s1_inv;
      s2_cls   <= s1_cls;
      s2_exp   <= exp_norm;
      s2_man   <= prod_norm;
    end
  end

  // Round to nearest even on the kept MAN_W+1 bits.
  logic [MAN_W:0]        kept;
  logic                  guard, sticky, round_up;
  logic [MAN_W+1:0]      man_sum;
  logic [MAN_W-1:0]      frac_r;
  logic signed [EW2-1:0] exp_r;
  assign kept     = s2_man[PW-1:MAN_W+1];
  assign guard    = s2_man[MAN_W];
  assign sticky   = |s2_man[MAN_W-1:0];
  assign round_up = guard && (sticky || kept[0]);
  assign man_sum  = {1'b0, kept} + {{(MAN_W+1){1'b0}}, round_up};
  assign frac_r   = man_sum[MAN_W+1] ? man_sum[MAN_W:1] : man_sum[MAN_W-1:0];
  assign exp_r    = man_sum[MAN_W+1] ? s2_exp + ONE_S : s2_exp;

  logic                  s3_valid, s3_sign, s3_inv, s3_inexact;
  cls_t                  s3_cls;
  logic signed [EW2-1:0] s3_exp;
  logic [MAN_W-1:0]      s3_frac;

  // Stage 3: register the rounded mantissa and final exponent.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s3_valid   <= 1'b0;
      s3_sign    <= 1'b0;
      s3_inv     <= 1'b0;
      s3_inexact <= 1'b0;
      s3_cls     <= CLS_NORM;
      s3_exp     <= '0;
      s3_frac    <= '0;
    end else if (advance) begin
      s3_valid   <= s2_valid;
      s3_sign    <= s2_sign;
      s3_inv     <= s2_inv;
      s3_inexact <= guard || sticky;
      s3_cls     <= s2_cls;
      s3_exp     <= exp_r;
      s3_frac    <= frac_r;
    end
  end

  logic [W-1:0] res_d;
  logic [3:0]   flg_d;

  // Range check and pack; flags are {invalid, overflow, underflow, inexact}.
  always_comb begin
    res_d = '0;
    flg_d = '0;
    case (s3_cls)
      CLS_NAN: begin
        res_d = QNAN;
        flg_d = {s3_inv, 3'b000};
      end
      CLS_INF:  res_d = {s3_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      CLS_ZERO: res_d = {s3_sign, {(W-1){1'b0}}};
      default: begin
        if (s3_exp >= EXP_TOP) begin
          res_d = {s3_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
          flg_d = 4'b0101;
        end else if (s3_exp < ONE_S) begin
          res_d = {s3_sign, {(W-1){1'b0}}};
          flg_d = 4'b0011;
        end else begin
          res_d = {s3_sign, s3_exp[EXP_W-1:0], s3_frac};
          flg_d = {3'b000, s3_inexact};
        end
      end
    endcase
  end

  // Output register: holds result and flags while the consumer stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      result    <= '0;
      flags     <= '0;
    end else if (advance) begin
      out_valid <= s3_valid;
      if (s3_valid) begin
        result <= res_d;
        flags  <= flg_d;
      end
    end
  end

endmodule

// File: doc/fp_mult_pipe.md
Name: fp_mult_pipe

Overview:
- Parametrised, pipelined IEEE-754-style floating-point multiplier; successor to the combinational single-precision multiplier.
- Generic exponent and mantissa widths, round-to-nearest-even, full special-case handling and exception flags.
- Valid/ready handshake with backpressure, so it can sit directly in the FPU datapath between the operand-issue logic and the result writeback.

Parameters:
EXP_W, 8, exponent field width (bias = 2^(EXP_W-1)-1)
MAN_W, 23, stored mantissa (fraction) width; total word width W = 1+EXP_W+MAN_W

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
in_valid  in  1  operand pair valid
in_ready  out  1  block can accept operands this cycle
operand_a  in  W  multiplicand {sign, exp, frac}
operand_b  in  W  multiplier
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
result  out  W  product
flags  out  4  {invalid, overflow, underflow, inexact} for the result

Behaviour:
- Reset (async, rst=1): all pipeline valid bits 0, so out_valid=0; result=0 and flags=0. in_ready=1 once rst deasserts. Any in-flight operations are discarded.
- Pipeline has 3 register stages:
  - S1: unpack and classify; compute sign xor and exponent sum ea+eb-bias in EXP_W+2-bit signed.
  - S2: (MAN_W+1)x(MAN_W+1) mantissa product, then normalise. If product MSB is set, shift right 1 and exponent +1.
  - S3: RNE round, overflow/underflow check, pack; registered output.
- Latency: an input accepted at edge N (in_valid and in_ready) appears with out_valid=1 after edge N+3, given no stall.
- Stall is global: advance = !out_valid | out_ready; in_ready = advance. When advance=0, every stage holds its value. result and flags stay stable while out_valid=1 and out_ready=0.
- Throughput: one operation per cycle when out_ready is held high.
- Handshake: in_valid with in_ready=0 is not accepted; the source must hold operands. Bubbles (in_valid=0) propagate as invalid stages.
- Rounding (RNE): guard bit = first bit below LSB; sticky = OR of the remaining bits. Round up if guard & (sticky | LSB). A mantissa carry-out increments the exponent. inexact = guard | sticky.
- Subnormals: subnormal inputs are treated as zero with sign kept (flush-to-zero). Results whose final exponent is < 1 become signed zero, with underflow=1 and inexact=1.
- Overflow: final exponent >= 2^EXP_W-1 gives signed infinity, with overflow=1 and inexact=1.
- Special cases (priority order):
  1. NaN on either input -> canonical qNaN {0, all-ones exp, frac MSB=1, rest 0}; invalid=1 only if an input is a signalling NaN.
  2. inf x 0 -> canonical qNaN, invalid=1.
  3. inf x finite -> signed infinity, no flags.
  4. zero x finite -> signed zero, no flags.
- Sign of every non-NaN result = sign_a xor sign_b.
- Flags apply only to the accompanying result; they are not sticky.

Test Plan:
- Basic, with EXP_W=8, MAN_W=23 and out_ready=1: 0x3fc00000 x 0x3fc00000 -> 0x40100000 three cycles after acceptance, flags=0. Also 0x3f800000 x 0xc0000000 -> 0xc0000000.
- Rounding: 0x3f800001 x 0x3f800001 -> 0x3f800002, inexact=1. Then 0x3fffffff x 0x3fffffff -> 0x407ffffe, inexact=1.
- Specials and flags:
  - 0x7f800000 x 0x00000000 -> 0x7fc00000, invalid=1.
  - 0x7f7fffff x 0x40000000 -> 0x7f800000, overflow=1, inexact=1.
  - 0x00800000 x 0x3f000000 -> 0x00000000, underflow=1, inexact=1.
  - 0x80000000 x 0x3f800000 -> 0x80000000.
- Backpressure: stream 5 back-to-back ops with out_ready=0 from cycle 4 for 3 cycles. Required response:
  - in_ready=0 during the stall;
  - result held stable;
  - no loss or duplication;
  - results emerge in order when out_ready returns to 1.
- Reset mid-operation: assert rst with 3 ops in flight. out_valid drops to 0 immediately (async) and no stale result appears after release. The first new op completes 3 cycles after acceptance.
- Half precision (EXP_W=5, MAN_W=10): 0x3e00 x 0x3e00 -> 0x4080; 0x7bff x 0x4000 -> 0x7c00, overflow=1.
